// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared memop encodings, FSM states and counter width for dmem_responder
package dmem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Unsigned sub-word ops have no meaning for stores.
  function automatic logic memop_legal(input logic [2:0] op, input logic wen);
    case (op)
      MEMOP_B, MEMOP_H, MEMOP_W: memop_legal = 1'b1;
      MEMOP_BU, MEMOP_HU:        memop_legal = !wen;
      default:                   memop_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and extraction/extension for loads
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b0
) (
  input  logic [2:0]  memop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        mis_raw;

  // H ignores addr[0] and W ignores addr[1:0], so misaligned accesses fall onto natural alignment.
  always_comb begin
    case (addr_lo)
      2'd0:    rd_byte = rdata_word[7:0];
      2'd1:    rd_byte = rdata_word[15:8];
      2'd2:    rd_byte = rdata_word[23:16];
      default: rd_byte = rdata_word[31:24];
    endcase
    rd_half    = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
    byte_en    = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    mis_raw    = 1'b0;
    case (memop)
      MEMOP_B, MEMOP_BU: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = (memop == MEMOP_B) ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
      end
      MEMOP_H, MEMOP_HU: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = (memop == MEMOP_H) ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
        mis_raw    = addr_lo[0];
      end
      MEMOP_W: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata_word;
        mis_raw    = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

  assign misaligned = ALIGN_CHECK && mis_raw;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with valid/ready request and response
// Define DMEM_ALIGN_CHECK_EN to fault misaligned H/W accesses instead of force-aligning them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [29:0] DEPTH_L   = 30'(DEPTH_WORDS);
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             wen_q;
  logic [2:0]       memop_q;
  logic [31:0]      addr_q, wdata_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [29:0]      word_off;
  logic [IDX_W-1:0] idx;
  logic             accept, commit, range_err, fault, misaligned;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_lane, rdata_ext;

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // The explicit compare catches addresses below the base that the wrapped offset would hide.
  assign word_off  = addr_q[31:2] - BASE_WORD;
  assign idx       = word_off[IDX_W-1:0];
  assign range_err = (addr_q < BASE_ADDR) || (word_off >= DEPTH_L);
  assign fault     = range_err || !memop_legal(memop_q, wen_q) || misaligned;

  dmem_lane_align #(.ALIGN_CHECK(ALIGN_CHECK)) u_lane_align (
    .memop      (memop_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata_word (mem[idx]),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = WAIT;
      WAIT: if (cnt == '0) begin
        state_nx = RESP;
        commit   = !rst;
      end
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      wen_q     <= 1'b0;
      memop_q   <= 3'b000;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen;
        memop_q <= req_memop;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        rsp_err   <= fault;
        rsp_rdata <= (fault || wen_q) ? 32'h0 : rdata_ext;
      end
    end
  end

  // No reset on the array: contents survive rst, and commit is already gated by it.
  always_ff @(posedge clk) begin
    if (commit && wen_q && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder (LATENCY 2 main instance, LATENCY 3 reset instance)
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam logic [2:0]  OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010, OP_BU = 3'b100, OP_HU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  req_memop;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  logic        rst3, req_valid3, req_ready3, req_wen3, rsp_valid3, rsp_ready3, rsp_err3;
  logic [2:0]  req_memop3;
  logic [31:0] req_addr3, req_wdata3, rsp_rdata3;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [32:0] exp_q [$];
  logic [32:0] mon_exp;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3), .req_wen(req_wen3),
    .req_memop(req_memop3), .req_addr(req_addr3), .req_wdata(req_wdata3), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
  );

  // Scoreboard: every accepted response on the main instance is checked against the queue head.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1 && rst === 1'b0) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL rsp_unexpected: got err=%b rdata=%h, required no response", rsp_err, rsp_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== mon_exp)
          $display("FAIL rsp_data: got err=%b rdata=%h, required err=%b rdata=%h",
                   rsp_err, rsp_rdata, mon_exp[32], mon_exp[31:0]);
        else pass_cnt++;
      end
    end
  end

  task automatic issue(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, output int lat);
    int k = 0;
    while (req_ready !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    if (req_ready !== 1'b1) begin
      total_cnt++;
      $display("FAIL issue_ready_timeout: req_ready=%b, required 1", req_ready);
      lat = -1;
      return;
    end
    req_valid = 1'b1; req_wen = wen; req_memop = op; req_addr = addr; req_wdata = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    if (rsp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_wen = 1'b0; req_memop = OP_W; req_addr = BASE; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (req_ready !== 1'b0) $display("FAIL reset_req_ready_in_rst: got %b, required 0", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid_in_rst: got %b, required 0", rsp_valid);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready_after: got %b, required 1", req_ready);
    else pass_cnt++;
    total_cnt++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0)
      $display("FAIL reset_rsp_outputs: got valid=%b err=%b rdata=%h, required all 0", rsp_valid, rsp_err, rsp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_word;
    int lat;
    issue(1'b1, OP_W, BASE + 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, lat);
    total_cnt++;
    if (lat !== 2) $display("FAIL word_store_latency: got %0d, required 2", lat);
    else pass_cnt++;
    issue(1'b0, OP_W, BASE + 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, lat);
    total_cnt++;
    if (lat !== 2) $display("FAIL word_load_latency: got %0d, required 2", lat);
    else pass_cnt++;
  endtask

  task automatic test_subword_loads;
    logic [2:0]  ops  [8] = '{OP_B, OP_BU, OP_B, OP_BU, OP_H, OP_HU, OP_B, OP_H};
    logic [31:0] offs [8] = '{32'h21, 32'h21, 32'h22, 32'h22, 32'h22, 32'h22, 32'h23, 32'h20};
    logic [31:0] exps [8] = '{32'h0000_007F, 32'h0000_007F, 32'hFFFF_FF81, 32'h0000_0081,
                              32'hFFFF_8081, 32'h0000_8081, 32'hFFFF_FF80, 32'h0000_7F80};
    int lat;
    issue(1'b1, OP_W, BASE + 32'h20, 32'h8081_7F80, 32'h0, 1'b0, lat);
    for (int i = 0; i < 8; i++) issue(1'b0, ops[i], BASE + offs[i], 32'h0, exps[i], 1'b0, lat);
  endtask

  task automatic test_store_lanes;
    int lat;
    issue(1'b1, OP_W, BASE + 32'h20, 32'h1122_3344, 32'h0, 1'b0, lat);
    issue(1'b1, OP_B, BASE + 32'h23, 32'hFFFF_FFAA, 32'h0, 1'b0, lat);
    issue(1'b0, OP_W, BASE + 32'h20, 32'h0, 32'hAA22_3344, 1'b0, lat);
    issue(1'b1, OP_H, BASE + 32'h20, 32'h9999_BEEF, 32'h0, 1'b0, lat);
    issue(1'b0, OP_W, BASE + 32'h20, 32'h0, 32'hAA22_BEEF, 1'b0, lat);
    issue(1'b1, OP_B, BASE + 32'h21, 32'h0000_0055, 32'h0, 1'b0, lat);
    issue(1'b1, OP_H, BASE + 32'h22, 32'h0000_1234, 32'h0, 1'b0, lat);
    issue(1'b0, OP_W, BASE + 32'h20, 32'h0, 32'h1234_55EF, 1'b0, lat);
  endtask

  task automatic test_faults;
    int lat;
    issue(1'b1, OP_W, BASE,            32'h5A5A_5A5A, 32'h0, 1'b0, lat);
    issue(1'b1, OP_W, BASE + 32'h4,    32'h600D_CAFE, 32'h0, 1'b0, lat);
    issue(1'b0, OP_W, 32'h7FFF_FFFC,   32'h0,         32'h0, 1'b1, lat);
    issue(1'b0, OP_W, 32'h0000_0000,   32'h0,         32'h0, 1'b1, lat);
    issue(1'b0, OP_W, 32'hFFFF_FFFC,   32'h0,         32'h0, 1'b1, lat);
    issue(1'b1, OP_W, BASE + 4*DEPTH,  32'h1234_5678, 32'h0, 1'b1, lat);
    issue(1'b0, OP_W, BASE,            32'h0,         32'h5A5A_5A5A, 1'b0, lat);
    issue(1'b1, OP_W, BASE + 4*DEPTH - 4, 32'h0BAD_F00D, 32'h0, 1'b0, lat);
    issue(1'b0, OP_W, BASE + 4*DEPTH - 4, 32'h0,      32'h0BAD_F00D, 1'b0, lat);
    issue(1'b0, 3'b011, BASE,          32'h0,         32'h0, 1'b1, lat);
    issue(1'b1, OP_BU, BASE + 32'h4,   32'hFFFF_FFFF, 32'h0, 1'b1, lat);
    issue(1'b1, OP_HU, BASE + 32'h4,   32'hFFFF_FFFF, 32'h0, 1'b1, lat);
    issue(1'b0, OP_W, BASE + 32'h4,    32'h0,         32'h600D_CAFE, 1'b0, lat);
`ifdef DMEM_ALIGN_CHECK_EN
    issue(1'b0, OP_W, BASE + 32'h2,    32'h0,         32'h0, 1'b1, lat);
    issue(1'b1, OP_H, BASE + 32'h1,    32'h0000_7777, 32'h0, 1'b1, lat);
    issue(1'b0, OP_W, BASE,            32'h0,         32'h5A5A_5A5A, 1'b0, lat);
`else
    issue(1'b0, OP_W, BASE + 32'h2,    32'h0,         32'h5A5A_5A5A, 1'b0, lat);
    issue(1'b1, OP_H, BASE + 32'h1,    32'h0000_7777, 32'h0, 1'b0, lat);
    issue(1'b0, OP_W, BASE,            32'h0,         32'h5A5A_7777, 1'b0, lat);
`endif
  endtask

  task automatic test_backpressure;
    int lat;
    issue(1'b1, OP_W, BASE + 32'h40, 32'hCAFE_F00D, 32'h0, 1'b0, lat);
    rsp_ready = 1'b0;
    issue(1'b0, OP_W, BASE + 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {3'b100, 32'hCAFE_F00D})
        $display("FAIL backpressure_hold: cycle %0d got valid=%b ready=%b err=%b rdata=%h, required valid=1 ready=0 err=0 rdata=cafef00d",
                 c, rsp_valid, req_ready, rsp_err, rsp_rdata);
      else pass_cnt++;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL backpressure_release: got valid=%b ready=%b, required valid=0 ready=1", rsp_valid, req_ready);
    else pass_cnt++;
  endtask

  task automatic issue3(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                        output int lat);
    int k = 0;
    rdata = 32'hxxxx_xxxx; err = 1'bx; lat = -1;
    while (req_ready3 !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    if (req_ready3 !== 1'b1) begin
      total_cnt++;
      $display("FAIL issue3_ready_timeout: req_ready=%b, required 1", req_ready3);
      return;
    end
    req_valid3 = 1'b1; req_wen3 = wen; req_memop3 = op; req_addr3 = addr; req_wdata3 = wdata;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    lat = 0;
    while (rsp_valid3 !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    rdata = rsp_rdata3; err = rsp_err3;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] rd;
    logic        er;
    int          lat;
    rsp_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst3 = 1'b0;
    issue3(1'b1, OP_W, BASE + 32'h50, 32'h0101_0101, rd, er, lat);
    total_cnt++;
    if (lat !== 3 || er !== 1'b0)
      $display("FAIL l3_store: got latency=%0d err=%b, required latency=3 err=0", lat, er);
    else pass_cnt++;
    req_valid3 = 1'b1; req_wen3 = 1'b1; req_memop3 = OP_W; req_addr3 = BASE + 32'h50; req_wdata3 = 32'h0202_0202;
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    rst3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({rsp_valid3, req_ready3} !== 2'b00)
      $display("FAIL l3_in_reset: got valid=%b ready=%b, required 0 0", rsp_valid3, req_ready3);
    else pass_cnt++;
    rst3 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if ({rsp_valid3, req_ready3} !== 2'b01)
      $display("FAIL l3_after_reset: got valid=%b ready=%b, required valid=0 ready=1", rsp_valid3, req_ready3);
    else pass_cnt++;
    issue3(1'b0, OP_W, BASE + 32'h50, 32'h0, rd, er, lat);
    total_cnt++;
    if ({er, rd} !== {1'b0, 32'h0101_0101})
      $display("FAIL l3_dropped_store: got err=%b rdata=%h, required err=0 rdata=01010101", er, rd);
    else pass_cnt++;
  endtask

  initial begin
    rst3 = 1'b1; req_valid3 = 1'b0; rsp_ready3 = 1'b1;
    req_wen3 = 1'b0; req_memop3 = OP_W; req_addr3 = BASE; req_wdata3 = 32'h0;
    test_reset();
    test_word();
    test_subword_loads();
    test_store_lanes();
    test_faults();
    test_backpressure();
    test_reset_mid_op();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1);
  end

endmodule
